uart_rx_param: RTL

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_rx_param.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: 16x oversampling, 3-sample majority vote, optional parity,
// 1 or 2 stop bits, break detection and a single-word holding register with overrun tracking.
module uart_rx_param #(
    parameter int CLK_FREQ  = 50000000,
    parameter int UART_BPS  = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 uart_rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 break_det,
    output logic                 busy
);

    localparam int OSR_DIV = CLK_FREQ / (UART_BPS * 16);
    localparam int PW      = (OSR_DIV > 1) ? $clog2(OSR_DIV) : 1;
    localparam int BCW     = $clog2(DATA_BITS + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]           state;
    logic                 rxd_s1, rxd_s2, rxd_d;
    logic [PW-1:0]        presc;
    logic [3:0]           tcnt;
    logic [BCW-1:0]       bitcnt;
    logic                 stop_cnt;
    logic                 s7, s8;
    logic [DATA_BITS-1:0] shreg;
    logic                 all_zero;
    logic                 perr_acc, ferr_acc;
    logic                 done;
    logic                 fall, tick, vote_t, bit_end, vote, par_xor;

    assign fall    = rxd_d & ~rxd_s2;
    assign tick    = (presc == PW'(OSR_DIV - 1));
    assign vote_t  = tick && (tcnt == 4'd9);
    assign bit_end = tick && (tcnt == 4'd15);
    assign vote    = (s7 & s8) | (s7 & rxd_s2) | (s8 & rxd_s2);
    assign par_xor = (^shreg) ^ vote;
    assign busy    = (state != S_IDLE);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
            rxd_d  <= 1'b1;
        end else begin
            rxd_s1 <= uart_rxd;
            rxd_s2 <= rxd_s1;
            rxd_d  <= rxd_s2;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= S_IDLE;
            presc     <= '0;
            tcnt      <= '0;
            bitcnt    <= '0;
            stop_cnt  <= 1'b0;
            s7        <= 1'b0;
            s8        <= 1'b0;
            shreg     <= '0;
            all_zero  <= 1'b0;
            perr_acc  <= 1'b0;
            ferr_acc  <= 1'b0;
            done      <= 1'b0;
            break_det <= 1'b0;
        end else begin
            done      <= 1'b0;
            break_det <= 1'b0;
            if (state == S_IDLE) begin
                presc <= '0;
                tcnt  <= '0;
                if (fall) begin
                    state    <= S_START;
                    bitcnt   <= '0;
                    stop_cnt <= 1'b0;
                    all_zero <= 1'b1;
                    perr_acc <= 1'b0;
                    ferr_acc <= 1'b0;
                end
            end else begin
                if (tick) begin
                    presc <= '0;
                    tcnt  <= tcnt + 4'd1;
                end else begin
                    presc <= presc + PW'(1);
                end
                if (tick && tcnt == 4'd7) s7 <= rxd_s2;
                if (tick && tcnt == 4'd8) s8 <= rxd_s2;

                case (state)
                    S_START: begin
                        if (vote_t && vote) state <= S_IDLE;
                        else if (bit_end)   state <= S_DATA;
                    end
                    S_DATA: begin
                        if (vote_t) begin
                            shreg    <= {vote, shreg[DATA_BITS-1:1]};
                            bitcnt   <= bitcnt + BCW'(1);
                            all_zero <= all_zero & ~vote;
                        end
                        if (bit_end && bitcnt == BCW'(DATA_BITS))
                            state <= (PARITY != 0) ? S_PARITY : S_STOP;
                    end
                    S_PARITY: begin
                        if (vote_t) begin
                            all_zero <= all_zero & ~vote;
                            perr_acc <= (PARITY == 1) ? ~par_xor : par_xor;
                        end
                        if (bit_end) state <= S_STOP;
                    end
                    S_STOP: begin
                        // Leaving at the vote of the last stop bit lets a back-to-back start edge be caught.
                        if (vote_t) begin
                            if (!stop_cnt && all_zero && !vote) begin
                                break_det <= 1'b1;
                                state     <= S_IDLE;
                            end else begin
                                ferr_acc <= ferr_acc | ~vote;
                                if (stop_cnt == 1'(STOP_BITS - 1)) begin
                                    done  <= 1'b1;
                                    state <= S_IDLE;
                                end else begin
                                    stop_cnt <= 1'b1;
                                end
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (done) begin
            if (!rx_valid || rx_ready) begin
                rx_data    <= shreg;
                parity_err <= perr_acc;
                frame_err  <= ferr_acc;
                rx_valid   <= 1'b1;
                if (rx_valid) overrun <= 1'b0;
            end else begin
                overrun <= 1'b1;
            end
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end
    end

endmodule
